// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory that streams in a program, then feeds the core's IR
module imem_loader #(
  parameter int AW    = 7,
  parameter int DEPTH = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_valid,
  input  logic [31:0]   load_data,
  input  logic          load_last,
  output logic          load_ready,
  input  logic          reload,
  output logic          core_rst_n,
  input  logic [31:0]   IR_addr,
  output logic [31:0]   IR,
  output logic [AW:0]   word_count,
  output logic          full_stop
);
  typedef enum logic {LOAD, RUN} state_t;
  state_t        state, state_n;
  logic [AW:0]   wc_n;
  logic          fs_n;
  logic          xfer;
  logic [AW-1:0] idx;
  logic [31:0]   mem [DEPTH];
  logic          unused_byte_bits;
  // the core is released exactly while the state register holds RUN, so this stays a registered signal
  assign load_ready       = state == LOAD;
  assign core_rst_n       = state == RUN;
  assign xfer             = rst_n && load_valid && load_ready;
  assign idx              = IR_addr[AW+1:2];
  assign unused_byte_bits = ^IR_addr[1:0];
  // stale words beyond word_count stay in the array but are masked to NOP here
  assign IR = (IR_addr[31:AW+2] == '0 && {1'b0, idx} < word_count) ? mem[idx] : '0;
  // next-state: count transfers, leave LOAD on last word or full array, restart on reload
  always_comb begin
    state_n = state;
    wc_n    = word_count;
    fs_n    = full_stop;
    if (xfer) begin
      wc_n = word_count + (AW+1)'(1);
      if (load_last || &word_count[AW-1:0]) begin
        state_n = RUN;
        fs_n    = !load_last;
      end
    end else if (state == RUN && reload) begin
      state_n = LOAD;
      wc_n    = '0;
      fs_n    = 1'b0;
    end
  end
  // control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD;
      word_count <= '0;
      full_stop  <= 1'b0;
    end else begin
      state      <= state_n;
      word_count <= wc_n;
      full_stop  <= fs_n;
    end
  end
  // program array, never cleared
  always_ff @(posedge clk) begin
    if (xfer) mem[word_count[AW-1:0]] <= load_data;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction memory and program loader placed directly upstream of the single-cycle MIPS core. It accepts program words over a valid/ready stream, stores them in a word-addressed instruction array, and holds the core in reset until loading completes. It then serves the core's `IR` combinationally from `IR_addr`, so a new instruction is available every cycle.

## Interface

**Parameters**
- `AW`, default 7: word-address width. Matches the core's 7-bit data-memory `A` width.
- `DEPTH`, default 128: instruction words stored. Must equal 2^AW.

**Ports**
- `clk` input, 1: positive-edge clock, shared with the core.
- `rst_n` input, 1: asynchronous, active-low reset.
- `load_valid` input, 1: a program word is presented.
- `load_data` input, 32: program word. Words are written in order starting at word 0.
- `load_last` input, 1: qualifies the final word of the program.
- `load_ready` output, 1: the loader can accept a word.
- `reload` input, 1: single-cycle pulse that restarts loading. Honoured only in RUN.
- `core_rst_n` output, 1: active-low reset driven to the core's `rst_n`.
- `IR_addr` input, 32: byte address from the core's PC.
- `IR` output, 32: instruction at `IR_addr`.
- `word_count` output, AW+1: number of words loaded.
- `full_stop` output, 1: loading ended because the array filled without `load_last`.

## Operation

- There are two states, LOAD and RUN. Async reset forces LOAD with `word_count`=0, `full_stop`=0 and `core_rst_n`=0.
- `load_ready` = (state==LOAD). A transfer happens when `load_valid` && `load_ready` are both high on a rising clk edge.
- On each transfer:
  - write `mem[word_count[AW-1:0]]` with `load_data`;
  - increment `word_count`.
- LOAD→RUN occurs on the clock edge of a transfer that meets either condition:
  - `load_last`=1, or
  - the transfer is the DEPTH-th word. In this case `full_stop` is set to 1 on the same edge, unless `load_last` was also 1.
- RUN behaviour:
  - `load_ready`=0; `load_valid` and `load_data` are ignored.
  - `core_rst_n`=1.
- `reload` pulse in RUN:
  - next state is LOAD;
  - `word_count`←0, `full_stop`←0, `core_rst_n`←0.
- `reload` in LOAD is ignored.
- Instruction read is combinational:
  - index = `IR_addr[AW+1:2]`; `IR_addr[1:0]` is ignored.
  - `IR` = `mem[index]` when `IR_addr[31:AW+2]`==0 and index < `word_count`; otherwise `IR` = 32'h0000_0000 (NOP).
- Memory contents are not cleared by reset or reload. Stale words are masked by the `word_count` comparison.
- `IR` follows the same read rules during LOAD, but the core is held in reset and ignores it.

## Timing

- Reset values:
  - `load_ready`=1
  - `core_rst_n`=0
  - `word_count`=0
  - `full_stop`=0
  - `IR`=0
- No transfer occurs while `rst_n` is low.
- `core_rst_n` is a registered output. It goes to 1 on the same edge that accepts the last word. The core's PC leaves 0 on the following edge, so its first fetch of address 0 sees the complete program.
- Write-to-read latency is one edge: a word written at edge N is visible on `IR` after edge N.
- Gaps in `load_valid` stall loading with no penalty; state and count hold.
- Async reset mid-LOAD discards progress: `word_count` returns to 0 and loading restarts from word 0.
- Async reset in RUN returns to LOAD and re-holds the core; the program must be reloaded.
- Simultaneous `reload` and a `load_valid` word in RUN: the word is not accepted (`load_ready`=0 that cycle). Loading starts on the next cycle.
- `word_count` saturates at DEPTH and never wraps. Once it reaches DEPTH, a transfer is impossible because the state is RUN.

## Test plan

- Reset, then load 32'h2001_0005, 32'h0021_0820, 32'h0800_0000 (`load_last` on the third) → `core_rst_n` rises on the third accept edge; `word_count`=3; `IR` at `IR_addr`=0/4/8 returns those words; `IR_addr`=12 returns 0; `full_stop`=0.
- Load with random 0–3 cycle `load_valid` gaps, 10 words → words stored in order; `word_count`=10; `load_ready` stays 1 until the last word is accepted.
- Load 128 words with `load_last` never set → RUN after word 128; `full_stop`=1; `load_ready`=0; a 129th `load_valid` is not accepted and `mem[0]` is unchanged.
- In RUN, `IR_addr`=32'h0000_0200 or 32'h8000_0000 → `IR`=0. `IR_addr`=32'h0000_0006 returns word 1.
- In RUN with 10 words, pulse `reload` → `core_rst_n`=0 and `word_count`=0 after the edge. `IR` at address 4 returns 0 until word 1 is rewritten. Then load 2 new words with `load_last` → old words 2–9 remain masked (`IR`=0).
- Assert `rst_n` low after 5 of 8 words → all outputs return to reset values immediately. After release, reload 8 words → `word_count`=8 and `core_rst_n`=1.
